// File: rtl/i3c_ctrl_pkg.sv
// ============================================================================
// i3c_ctrl_pkg : shared types for the I3C controller TX path
// Rev 1.0
// ============================================================================
`default_nettype none

package i3c_ctrl_pkg;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    WaitIdle = 2'd1,
    SendByte = 2'd2,
    SendTbit = 2'd3
  } tx_seq_state_e;

  typedef enum logic {
    TbitParity = 1'b0,
    TbitEod    = 1'b1
  } tbit_mode_e;

  // EOD mode reports "more data follows", parity mode makes byte+T odd.
  function automatic logic tbit_calc(tbit_mode_e mode, logic [7:0] data, logic last);
    return (mode == TbitEod) ? ~last : ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_byte_prefetch.sv
// ============================================================================
// tx_byte_prefetch : one-entry valid/ready holding register with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_byte_prefetch
  import i3c_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       enable_i,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       pop_i,
  output logic       full_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o
);

  logic       full_q;
  logic [7:0] data_q;
  logic       last_q;
  logic       w_push;

  assign in_ready_o = ~full_q & enable_i;
  assign w_push     = in_valid_i & in_ready_o;

  // A push wins over a pop in the same cycle, so the entry stays occupied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      last_q <= 1'b0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (w_push) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
      last_q <= in_last_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o     = full_q;
  assign out_data_o = data_q;
  assign out_last_o = last_q;

endmodule

`default_nettype wire

// File: rtl/bus_tx_sequencer.sv
// ============================================================================
// bus_tx_sequencer : feeds bus_tx_flow a gap-free byte / T-bit request stream
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_tx_sequencer
  import i3c_ctrl_pkg::*;
#(
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            tbit_mode_i,
  input  logic [7:0]      tx_data_i,
  input  logic            tx_last_i,
  input  logic            tx_valid_i,
  output logic            tx_ready_o,
  output logic            req_byte_o,
  output logic            req_bit_o,
  output logic [7:0]      req_value_o,
  input  logic            bus_tx_done_i,
  input  logic            bus_tx_idle_i,
  input  logic            req_error_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            underflow_o,
  output logic            error_o,
  output logic [CntW-1:0] byte_count_o
);

  tx_seq_state_e   state_q, state_d;
  tbit_mode_e      mode_q, mode_d;
  logic [7:0]      cur_data_q, cur_data_d;
  logic            cur_last_q, cur_last_d;
  logic            req_byte_q, req_byte_d;
  logic            req_bit_q, req_bit_d;
  logic [7:0]      req_value_q, req_value_d;
  logic            done_q, done_d;
  logic            underflow_q, underflow_d;
  logic            error_q, error_d;
  logic [CntW-1:0] count_q, count_d;

  logic            busy;
  logic            flush;
  logic            pf_pop;
  logic            pf_full;
  logic [7:0]      pf_data;
  logic            pf_last;

  assign busy  = (state_q != Idle);
  assign flush = abort_i | (req_error_i & busy);

  tx_byte_prefetch u_prefetch (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush),
    .enable_i   (busy & ~cur_last_q),
    .in_data_i  (tx_data_i),
    .in_last_i  (tx_last_i),
    .in_valid_i (tx_valid_i),
    .in_ready_o (tx_ready_o),
    .pop_i      (pf_pop),
    .full_o     (pf_full),
    .out_data_o (pf_data),
    .out_last_o (pf_last)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cur_data_d  = cur_data_q;
    cur_last_d  = cur_last_q;
    req_byte_d  = req_byte_q;
    req_bit_d   = req_bit_q;
    req_value_d = req_value_q;
    count_d     = count_q;
    done_d      = 1'b0;
    underflow_d = 1'b0;
    error_d     = 1'b0;
    pf_pop      = 1'b0;

    if (flush) begin
      state_d     = Idle;
      req_byte_d  = 1'b0;
      req_bit_d   = 1'b0;
      req_value_d = 8'h00;
      cur_last_d  = 1'b0;
      error_d     = busy;
    end else begin
      unique case (state_q)
        Idle: begin
          if (start_i) begin
            state_d    = WaitIdle;
            count_d    = '0;
            mode_d     = tbit_mode_e'(tbit_mode_i);
            cur_last_d = 1'b0;
          end
        end
        WaitIdle: begin
          if (bus_tx_idle_i && pf_full) begin
            state_d     = SendByte;
            req_byte_d  = 1'b1;
            req_value_d = pf_data;
            cur_data_d  = pf_data;
            cur_last_d  = pf_last;
            pf_pop      = 1'b1;
          end
        end
        SendByte: begin
          if (bus_tx_done_i) begin
            state_d     = SendTbit;
            req_byte_d  = 1'b0;
            req_bit_d   = 1'b1;
            req_value_d = {7'b0, tbit_calc(mode_q, cur_data_q, cur_last_q)};
          end
        end
        SendTbit: begin
          if (bus_tx_done_i) begin
            count_d = (count_q == {CntW{1'b1}}) ? count_q : count_q + CntW'(1);
            if (cur_last_q) begin
              state_d     = Idle;
              req_bit_d   = 1'b0;
              req_value_d = 8'h00;
              done_d      = 1'b1;
            end else if (pf_full) begin
              // Switch straight to the next byte so bus_tx_flow sees no idle cycle.
              state_d     = SendByte;
              req_bit_d   = 1'b0;
              req_byte_d  = 1'b1;
              req_value_d = pf_data;
              cur_data_d  = pf_data;
              cur_last_d  = pf_last;
              pf_pop      = 1'b1;
            end else begin
              state_d     = Idle;
              req_bit_d   = 1'b0;
              req_value_d = 8'h00;
              underflow_d = 1'b1;
            end
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      mode_q      <= TbitParity;
      cur_data_q  <= 8'h00;
      cur_last_q  <= 1'b0;
      req_byte_q  <= 1'b0;
      req_bit_q   <= 1'b0;
      req_value_q <= 8'h00;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cur_data_q  <= cur_data_d;
      cur_last_q  <= cur_last_d;
      req_byte_q  <= req_byte_d;
      req_bit_q   <= req_bit_d;
      req_value_q <= req_value_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign req_byte_o   = req_byte_q;
  assign req_bit_o    = req_bit_q;
  assign req_value_o  = req_value_q;
  assign busy_o       = busy;
  assign done_o       = done_q;
  assign underflow_o  = underflow_q;
  assign error_o      = error_q;
  assign byte_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_tx_sequencer.sv
// ============================================================================
// tb_bus_tx_sequencer : scoreboard bench with a bus_tx_flow responder model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_tx_sequencer;

  localparam int CNTW = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic            tbit_mode_i = 1'b0;
  logic [7:0]      tx_data_i = 8'h00;
  logic            tx_last_i = 1'b0;
  logic            tx_valid_i = 1'b0;
  logic            tx_ready_o;
  logic            req_byte_o;
  logic            req_bit_o;
  logic [7:0]      req_value_o;
  logic            bus_tx_done_i = 1'b0;
  logic            bus_tx_idle_i = 1'b1;
  logic            req_error_i = 1'b0;
  logic            busy_o;
  logic            done_o;
  logic            underflow_o;
  logic            error_o;
  logic [CNTW-1:0] byte_count_o;

  bus_tx_sequencer #(.CntW(CNTW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .tbit_mode_i(tbit_mode_i), .tx_data_i(tx_data_i), .tx_last_i(tx_last_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .req_byte_o(req_byte_o),
    .req_bit_o(req_bit_o), .req_value_o(req_value_o), .bus_tx_done_i(bus_tx_done_i),
    .bus_tx_idle_i(bus_tx_idle_i), .req_error_i(req_error_i), .busy_o(busy_o),
    .done_o(done_o), .underflow_o(underflow_o), .error_o(error_o),
    .byte_count_o(byte_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] d; logic l; } src_t;
  typedef struct { bit is_bit; logic [7:0] d; logic l; } exp_t;

  src_t src[$];
  exp_t expq[$];

  int checks = 0;
  int failures = 0;

  // Reference model: what the sequencer should be doing, in transaction terms.
  bit m_busy = 0;
  int m_kind = 0;          // 0 none, 1 byte request, 2 bit request
  int m_cnt = 0;
  bit e_done = 0, e_uf = 0, e_err = 0;
  bit last_pend = 0;
  bit cur_mode = 0;
  bit hs_q = 0;
  bit gaps = 0;
  int lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic exp_tbit(input exp_t e);
    return cur_mode ? ~e.l : ~^e.d;
  endfunction

  always @(negedge clk_i) begin : monitor
    exp_t it;
    bit   flush, hs, active;
    if (!rst_ni) begin
      m_busy = 0; m_kind = 0; m_cnt = 0;
      e_done = 0; e_uf = 0; e_err = 0;
      last_pend = 0; hs_q = 0;
      expq.delete();
      bus_tx_done_i = 1'b0;
      bus_tx_idle_i = 1'b1;
    end else begin
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("done_pulse", 32'(done_o), 32'(e_done));
      chk("underflow_pulse", 32'(underflow_o), 32'(e_uf));
      chk("error_pulse", 32'(error_o), 32'(e_err));
      chk("byte_count", 32'(byte_count_o), 32'(m_cnt));
      chk("req_kind", 32'({req_bit_o, req_byte_o}), 32'(m_kind));
      if (m_kind == 1 && expq.size() > 0)
        chk("req_value_byte", 32'(req_value_o), 32'(expq[0].d));
      if (m_kind == 2 && expq.size() > 0)
        chk("req_value_tbit", 32'(req_value_o[0]), 32'(exp_tbit(expq[0])));
      if (busy_o && last_pend)
        chk("ready_after_last", 32'(tx_ready_o), 32'(0));

      // bus_tx_flow responder: random completion latency, stray done while idle
      active = req_byte_o | req_bit_o;
      if (active) begin
        bus_tx_done_i = (lat == 0);
        lat = (lat == 0) ? int'($urandom_range(0, 2)) : lat - 1;
      end else begin
        bus_tx_done_i = ($urandom_range(0, 3) == 0);
      end
      bus_tx_idle_i = ~active & ($urandom_range(0, 3) != 0);

      flush = abort_i | (req_error_i & m_busy);
      hs    = tx_valid_i & tx_ready_o;
      e_done = 0; e_uf = 0; e_err = 0;
      if (flush) begin
        e_err = m_busy;
        m_busy = 0; m_kind = 0; last_pend = 0;
        expq.delete();
      end else if (start_i && !m_busy) begin
        m_busy = 1; m_cnt = 0; cur_mode = tbit_mode_i;
      end else if (m_kind != 0 && bus_tx_done_i) begin
        it = expq.pop_front();
        if (!it.is_bit) begin
          m_kind = 2;
        end else begin
          m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
          if (it.l) begin
            e_done = 1; m_busy = 0; m_kind = 0; last_pend = 0;
          end else if (expq.size() > 0) begin
            m_kind = 1;
          end else begin
            e_uf = 1; m_busy = 0; m_kind = 0;
          end
        end
      end else if (m_busy && m_kind == 0 && bus_tx_idle_i && expq.size() > 0) begin
        m_kind = 1;
      end
      if (hs && !flush) begin
        expq.push_back('{is_bit: 1'b0, d: tx_data_i, l: tx_last_i});
        expq.push_back('{is_bit: 1'b1, d: tx_data_i, l: tx_last_i});
        if (tx_last_i) last_pend = 1;
      end
      hs_q = hs;
    end
  end

  // TX queue source
  always @(posedge clk_i) begin
    #1;
    if (hs_q && src.size() > 0) void'(src.pop_front());
    hs_q = 0;
    if (src.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      tx_valid_i = 1'b1;
      tx_data_i  = src[0].d;
      tx_last_i  = src[0].l;
    end else begin
      tx_valid_i = 1'b0;
      tx_data_i  = 8'($urandom);
      tx_last_i  = 1'b0;
    end
  end

  task automatic do_start(input bit m);
    @(posedge clk_i); #2;
    tbit_mode_i = m;
    start_i = 1'b1;
    @(posedge clk_i); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #2;
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout busy_o=%0b required=0", busy_o);
    end
  endtask

  initial begin
    bit ok;
    int n, d, act;
    bit omit;

    repeat (2) @(posedge clk_i); #2;
    chk("reset_outputs", 32'({tx_ready_o, req_byte_o, req_bit_o, req_value_o, busy_o,
                              done_o, underflow_o, error_o, byte_count_o}), 32'(0));
    rst_ni = 1'b1;

    // 1: single parity byte
    src.push_back('{d: 8'hA5, l: 1'b1});
    do_start(1'b0);
    wait_idle(200);
    chk("t1_count", 32'(byte_count_o), 32'(1));

    // 2: two parity bytes, contiguous
    src.push_back('{d: 8'h01, l: 1'b0});
    src.push_back('{d: 8'hFF, l: 1'b1});
    do_start(1'b0);
    wait_idle(200);
    chk("t2_count", 32'(byte_count_o), 32'(2));

    // 3: end-of-data mode
    src.push_back('{d: 8'h10, l: 1'b0});
    src.push_back('{d: 8'h20, l: 1'b0});
    src.push_back('{d: 8'h30, l: 1'b1});
    do_start(1'b1);
    wait_idle(200);
    chk("t3_count", 32'(byte_count_o), 32'(3));

    // 4: underflow
    src.push_back('{d: 8'h55, l: 1'b0});
    do_start(1'b0);
    wait_idle(200);
    chk("t4_count", 32'(byte_count_o), 32'(1));

    // 5: abort during second byte
    for (int i = 0; i < 4; i++) src.push_back('{d: 8'(8'h61 + i), l: (i == 3)});
    do_start(1'b0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #2;
      if (req_byte_o && byte_count_o == 1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL t5_wait_second_byte req_byte_o=%0b required=1", req_byte_o);
    end
    abort_i = 1'b1;
    @(posedge clk_i); #2;
    abort_i = 1'b0;
    src.delete();
    chk("t5_reqs_low", 32'({req_byte_o, req_bit_o}), 32'(0));
    chk("t5_error", 32'(error_o), 32'(1));
    chk("t5_count", 32'(byte_count_o), 32'(1));
    chk("t5_prefetch_flushed", 32'(tx_ready_o), 32'(0));

    // 6: asynchronous reset during a T-bit
    src.push_back('{d: 8'h3C, l: 1'b0});
    src.push_back('{d: 8'h4D, l: 1'b1});
    do_start(1'b1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #2;
      if (req_bit_o) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL t6_wait_tbit req_bit_o=%0b required=1", req_bit_o);
    end
    #1;
    rst_ni = 1'b0;
    hs_q = 0;
    #1;
    chk("t6_async_reset", 32'({tx_ready_o, req_byte_o, req_bit_o, req_value_o, busy_o,
                               done_o, underflow_o, error_o, byte_count_o}), 32'(0));
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    src.delete();
    src.push_back('{d: 8'h77, l: 1'b1});
    do_start(1'b0);
    wait_idle(200);
    chk("t6_count", 32'(byte_count_o), 32'(1));

    // Randomized transfers: gaps, underflow, abort, bus error, ignored restart
    gaps = 1;
    for (int t = 0; t < 40; t++) begin
      n    = $urandom_range(1, 10);
      omit = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < n; i++)
        src.push_back('{d: 8'($urandom), l: (i == n - 1) && !omit});
      do_start(1'($urandom_range(0, 1)));
      act = $urandom_range(0, 5);
      if (act <= 2) begin
        d = $urandom_range(0, 12);
        repeat (d) @(posedge clk_i);
        #2;
        if (act == 0) abort_i = 1'b1;
        else if (act == 1) req_error_i = 1'b1;
        else begin start_i = 1'b1; tbit_mode_i = ~tbit_mode_i; end
        @(posedge clk_i); #2;
        abort_i = 1'b0; req_error_i = 1'b0; start_i = 1'b0;
      end
      wait_idle(600);
    end

    repeat (5) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
